i2c_master_controller: RTL
==========================

# i2c_master_controller

Single-byte I2C bus master that generates START, address/RW, one data byte and STOP on SCL/SDA. It is the upstream stage that drives `i2c_slave_controller`: the master sources SCL and shares SDA, with the slave at address 7'b0101010. The block runs from one system clock and derives SCL with a programmable divider. A user pulse launches each transaction, which is either one write byte or one read byte.

## Interface
- `CLK_DIV`, 4: system clocks per SCL quarter-period; legal range ≥ 2.
- `clk`  input  1  system clock, rising-edge.
- `rst_n`  input  1  reset: one clock; reset is asynchronous and active-low.
- `start`  input  1  one-cycle launch request; sampled only when `busy`=0.
- `addr`  input  7  slave address; latched on accept.
- `rw`  input  1  0 = write `data_in`, 1 = read into `data_out`; latched on accept.
- `data_in`  input  8  write byte; latched on accept.
- `data_out`  output  8  read byte; updated only at the end of a read; holds between transactions.
- `busy`  output  1  high from accept through the end of STOP.
- `done`  output  1  one-cycle pulse at transaction end.
- `ack_error`  output  1  address ACK was 1; valid with `done`; held until the next accept.
- `scl`  output  1  push-pull SCL.
- `sda`  inout  1  open-drain SDA: drives 0 or Z; an external pull-up is required.

## Operation
- States: IDLE, START, ADDR, ADDR_ACK, WDATA, WACK, RDATA, RNACK, STOP.
- **Quarter counter**
  - Counts 0..CLK_DIV-1 and is cleared on accept.
  - Its wrap ends the current quarter.
  - All SCL/SDA changes occur on quarter boundaries.
- **IDLE:** `scl`=1, SDA released, `busy`=0. When `start`=1:
  - latch `addr`, `rw`, `data_in`;
  - load shift register {addr, rw};
  - set `busy`=1, clear `ack_error`, go to START.
- **START (2 quarters)**
  - q0: scl=1, SDA released.
  - q1: scl=1, SDA=0.
- **Bit slot (4 quarters, MSB first)**
  - q0: scl=0, update SDA.
  - q1: scl=0.
  - q2: scl=1.
  - q3: scl=1.
  - SDA is sampled at the q2→q3 boundary.
- **ADDR:** 8 slots driving the shift register bits; SDA=0 for a 0 bit, released for a 1 bit.
- **ADDR_ACK:** 1 slot with SDA released.
  - Sampled 0: go to WDATA if rw=0, else RDATA.
  - Sampled 1: set `ack_error`, go to STOP.
- **WDATA:** 8 slots driving the latched `data_in`.
- **WACK:** 1 slot with SDA released. The sampled value is ignored, then go to STOP.
- **RDATA:** 8 slots with SDA released; each sample shifts into a read register.
- **RNACK:** 1 slot with SDA released (NACK); load `data_out` from the read register, then go to STOP.
- **STOP (3 quarters)**
  - q0: scl=0, SDA=0.
  - q1: scl=1, SDA=0.
  - q2: scl=1, SDA released.
  - Then go to IDLE: `busy`=0 and `done`=1 for one clk.
- `start` while `busy`=1 is ignored and not queued.

## Timing
- Reset values: `scl`=1, SDA released, `busy`=0, `done`=0, `ack_error`=0, `data_out`=8'h00, state IDLE, counters 0.
- Accept edge E0 is the edge where `start`=1 and `busy`=0. `busy` rises at E0.
- Full transaction is 2 + 18×4 + 3 = 77 quarters.
  - `done` is high in the cycle following edge E0 + 77×CLK_DIV.
  - `busy` falls on that same edge.
  - With CLK_DIV=4, this is 308 clocks.
- Address NACK path is 2 + 9×4 + 3 = 41 quarters, i.e. `done` at E0 + 41×CLK_DIV.
- SDA never changes while scl=1, except the START and STOP edges.
- Back-to-back: `start` in the `done` cycle is accepted. Its START q0 begins with scl already 1.
- Asynchronous `rst_n` low mid-transaction:
  - all outputs return to reset values immediately;
  - no STOP is generated;
  - `data_out` is cleared.
- Counter width is ceil(log2(CLK_DIV)). The bit counter is 3 bits and counts 7→0.

## Test plan
- **Write:** bench with pull-up and slave at 7'b0101010, CLK_DIV=4. Pulse start with addr=7'h2A, rw=0, data_in=8'hA5.
  - SDA bits at scl rises: 0101010 0, ACK 0, 10100101, ACK 0.
  - `done` at E0+308; `ack_error`=0.
  - Slave `data_in`=8'hA5.
- **Read:** addr=7'h2A, rw=1.
  - `data_out`=8'hCC at `done`, at E0+308.
  - Master releases SDA in the 9th data slot (NACK).
- **Wrong address:** addr=7'h15.
  - `ack_error`=1; STOP follows the ACK slot.
  - `done` at E0+164; no data slots appear.
- **Busy rejection:** pulse start again 20 clks after accept.
  - Ignored: exactly one `done` results and the addr latch is unchanged.
- **Reset mid-read:** assert `rst_n`=0 during RDATA bit 3.
  - scl=1, SDA=Z, busy=0, data_out=0 immediately.
  - A new write afterwards completes normally.
- **Protocol checker on every run:** SDA stable while scl=1 except START (fall) and STOP (rise).
  - Each scl high and low phase is ≥ 2×CLK_DIV clocks.

Source files
------------

// File: rtl/i2c_master_controller.sv
// Single-byte I2C bus master: START, 7-bit address + R/W, one data byte
// (write or read), STOP. SCL is push-pull; SDA is open-drain (drives 0 or Z).
// Every bus change lands on a quarter-period boundary of SCL, where one
// quarter is CLK_DIV system clocks.
module i2c_master_controller #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       busy,
    output logic       done,
    output logic       ack_error,
    output logic       scl,
    inout  wire        sda
);
    localparam int QW = $clog2(CLK_DIV);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ADDR_ACK,
        S_WDATA,
        S_WACK,
        S_RDATA,
        S_RNACK,
        S_STOP
    } state_t;

    state_t        r_state;
    logic [QW-1:0] r_qcnt;      // clocks within the current quarter
    logic [1:0]    r_phase;     // quarter index within the current state/slot
    logic [2:0]    r_bit;       // remaining bits in the current byte, 7 -> 0
    logic [7:0]    r_shift;     // outgoing address/data, or incoming read data
    logic [7:0]    r_wdata;
    logic          r_rw;
    logic          r_busy;
    logic          r_done;
    logic          r_ack_error;
    logic          r_scl;
    logic          r_sda_low;   // 1 = pull SDA low, 0 = release
    logic          r_sample;    // SDA captured at the q2->q3 boundary
    logic [7:0]    r_data_out;

    logic w_qwrap;
    logic w_sda_in;

    assign w_qwrap  = (r_qcnt == QW'(CLK_DIV - 1));
    assign w_sda_in = sda;
    assign sda      = r_sda_low ? 1'b0 : 1'bz;

    assign data_out  = r_data_out;
    assign busy      = r_busy;
    assign done      = r_done;
    assign ack_error = r_ack_error;
    assign scl       = r_scl;

    // Transaction sequencer: outputs for each quarter are registered at the
    // edge that starts that quarter, so SCL/SDA only move on quarter edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_qcnt      <= '0;
            r_phase     <= 2'd0;
            r_bit       <= 3'd0;
            r_shift     <= 8'h00;
            r_wdata     <= 8'h00;
            r_rw        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ack_error <= 1'b0;
            r_scl       <= 1'b1;
            r_sda_low   <= 1'b0;
            r_sample    <= 1'b0;
            r_data_out  <= 8'h00;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                r_qcnt <= '0;
                if (start) begin
                    r_state     <= S_START;
                    r_phase     <= 2'd0;
                    r_shift     <= {addr, rw};
                    r_rw        <= rw;
                    r_wdata     <= data_in;
                    r_busy      <= 1'b1;
                    r_ack_error <= 1'b0;
                    r_scl       <= 1'b1;
                    r_sda_low   <= 1'b0;
                end
            end else begin
                r_qcnt <= w_qwrap ? '0 : r_qcnt + QW'(1);
                if (w_qwrap) begin
                    r_phase <= r_phase + 2'd1;
                    case (r_state)
                        S_START: begin
                            if (r_phase == 2'd0) begin
                                // START condition: SDA falls while SCL is high
                                r_sda_low <= 1'b1;
                            end else begin
                                r_state   <= S_ADDR;
                                r_phase   <= 2'd0;
                                r_bit     <= 3'd7;
                                r_scl     <= 1'b0;
                                r_sda_low <= ~r_shift[7];
                            end
                        end
                        S_STOP: begin
                            case (r_phase)
                                2'd0:    r_scl <= 1'b1;
                                2'd1:    r_sda_low <= 1'b0;  // STOP: SDA rises, SCL high
                                default: begin
                                    r_state <= S_IDLE;
                                    r_phase <= 2'd0;
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                end
                            endcase
                        end
                        default: begin
                            // Four-quarter bit slot: low, low, high, high
                            case (r_phase)
                                2'd0: begin
                                end
                                2'd1: r_scl <= 1'b1;
                                2'd2: begin
                                    r_sample <= w_sda_in;
                                    if (r_state == S_RDATA) begin
                                        r_shift <= {r_shift[6:0], w_sda_in};
                                    end
                                end
                                default: begin
                                    // Slot end: SCL falls and the next slot's SDA is set
                                    r_scl <= 1'b0;
                                    case (r_state)
                                        S_ADDR, S_WDATA: begin
                                            if (r_bit != 3'd0) begin
                                                r_bit     <= r_bit - 3'd1;
                                                r_shift   <= {r_shift[6:0], 1'b0};
                                                r_sda_low <= ~r_shift[6];
                                            end else begin
                                                r_state   <= (r_state == S_ADDR) ? S_ADDR_ACK : S_WACK;
                                                r_sda_low <= 1'b0;
                                            end
                                        end
                                        S_ADDR_ACK: begin
                                            if (r_sample) begin
                                                r_ack_error <= 1'b1;
                                                r_state     <= S_STOP;
                                                r_sda_low   <= 1'b1;
                                            end else if (!r_rw) begin
                                                r_state   <= S_WDATA;
                                                r_bit     <= 3'd7;
                                                r_shift   <= r_wdata;
                                                r_sda_low <= ~r_wdata[7];
                                            end else begin
                                                r_state   <= S_RDATA;
                                                r_bit     <= 3'd7;
                                                r_sda_low <= 1'b0;
                                            end
                                        end
                                        S_RDATA: begin
                                            r_sda_low <= 1'b0;
                                            if (r_bit != 3'd0) begin
                                                r_bit <= r_bit - 3'd1;
                                            end else begin
                                                r_state <= S_RNACK;
                                            end
                                        end
                                        S_RNACK: begin
                                            r_data_out <= r_shift;
                                            r_state    <= S_STOP;
                                            r_sda_low  <= 1'b1;
                                        end
                                        default: begin
                                            // WACK: the acknowledge value is not used
                                            r_state   <= S_STOP;
                                            r_sda_low <= 1'b1;
                                        end
                                    endcase
                                end
                            endcase
                        end
                    endcase
                end
            end
        end
    end

endmodule
